// File: rtl/ahb_mem_arbiter.sv
// Two-requester arbiter for a single AHB-Lite memory port. Each grant runs one
// non-pipelined NONSEQ transfer (address phase, data phase) with a wait-state watchdog.
module ahb_mem_arbiter #(
    parameter int PRIORITY_MODE = 0,
    parameter int TIMEOUT       = 255
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        req0,
    input  logic        we0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    output logic [31:0] rdata0,
    output logic        done0,
    output logic        err0,

    input  logic        req1,
    input  logic        we1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    output logic [31:0] rdata1,
    output logic        done1,
    output logic        err1,

    output logic [31:0] HADDR,
    output logic        HWRITE,
    output logic [1:0]  HTRANS,
    output logic [2:0]  HSIZE,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [7:0] WDOG_LIMIT   = 8'(TIMEOUT);
    localparam int         NUM_REQ      = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10
    } state_t;

    state_t      state_reg, state_next;
    logic        owner_reg, owner_next;
    logic        last_reg, last_next;
    logic [7:0]  wdog_reg, wdog_next;
    logic [31:0] haddr_reg, haddr_next;
    logic        hwrite_reg, hwrite_next;

    logic [NUM_REQ-1:0] req_vec;
    logic [NUM_REQ-1:0] done_vec;
    logic [NUM_REQ-1:0] err_vec;
    logic [31:0]        rdata_arr [NUM_REQ];
    logic [31:0]        rd_data;

    logic        grant;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_we;

    assign req_vec   = {req1, req0};
    assign sel_addr  = owner_reg ? addr1  : addr0;
    assign sel_wdata = owner_reg ? wdata1 : wdata0;
    assign sel_we    = owner_reg ? we1    : we0;

    // A lone requester always wins; ties go to requester 0 or alternate with the last winner.
    always_comb begin
        grant = 1'b0;
        case (req_vec)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = (PRIORITY_MODE != 0) ? 1'b0 : ~last_reg;
            default: grant = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= ST_IDLE;
            owner_reg  <= 1'b0;
            last_reg   <= 1'b1;
            wdog_reg   <= 8'd0;
            haddr_reg  <= 32'd0;
            hwrite_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            owner_reg  <= owner_next;
            last_reg   <= last_next;
            wdog_reg   <= wdog_next;
            haddr_reg  <= haddr_next;
            hwrite_reg <= hwrite_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        owner_next  = owner_reg;
        last_next   = last_reg;
        wdog_next   = wdog_reg;
        haddr_next  = haddr_reg;
        hwrite_next = hwrite_reg;
        done_vec    = '0;
        err_vec     = '0;
        rd_data     = 32'd0;
        HTRANS      = TRANS_IDLE;
        HADDR       = 32'd0;
        HWRITE      = 1'b0;
        HWDATA      = 32'd0;

        case (state_reg)
            ST_IDLE: begin
                wdog_next = 8'd0;
                if (req_vec != '0) begin
                    owner_next = grant;
                    state_next = ST_ADDR;
                end
            end

            ST_ADDR: begin
                HTRANS = TRANS_NONSEQ;
                HADDR  = sel_addr;
                HWRITE = sel_we;
                if (HREADY) begin
                    // Latch the address phase so it stays visible through the data phase.
                    haddr_next  = sel_addr;
                    hwrite_next = sel_we;
                    wdog_next   = 8'd0;
                    state_next  = ST_DATA;
                end else if (wdog_reg == WDOG_LIMIT) begin
                    err_vec[owner_reg] = 1'b1;
                    last_next  = owner_reg;
                    wdog_next  = 8'd0;
                    state_next = ST_IDLE;
                end else begin
                    wdog_next = wdog_reg + 8'd1;
                end
            end

            ST_DATA: begin
                HADDR  = haddr_reg;
                HWRITE = hwrite_reg;
                HWDATA = sel_wdata;
                if (HREADY) begin
                    if (HRESP) begin
                        err_vec[owner_reg] = 1'b1;
                    end else begin
                        done_vec[owner_reg] = 1'b1;
                        rd_data = hwrite_reg ? 32'd0 : HRDATA;
                    end
                    last_next  = owner_reg;
                    wdog_next  = 8'd0;
                    state_next = ST_IDLE;
                end else if (wdog_reg == WDOG_LIMIT) begin
                    err_vec[owner_reg] = 1'b1;
                    last_next  = owner_reg;
                    wdog_next  = 8'd0;
                    state_next = ST_IDLE;
                end else begin
                    wdog_next = wdog_reg + 8'd1;
                end
            end

            default: begin
                state_next = ST_IDLE;
                wdog_next  = 8'd0;
            end
        endcase
    end

    // Read data is only driven toward the requester being completed.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign rdata_arr[gi] = done_vec[gi] ? rd_data : 32'd0;
        end
    endgenerate

    assign rdata0 = rdata_arr[0];
    assign rdata1 = rdata_arr[1];
    assign done0  = done_vec[0];
    assign done1  = done_vec[1];
    assign err0   = err_vec[0];
    assign err1   = err_vec[1];
    assign HSIZE  = 3'b010;

endmodule

// File: tb/tb_ahb_mem_arbiter.sv
// Directed bench: a round-robin and a fixed-priority arbiter (TIMEOUT=4) share one stimulus.
module tb_ahb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
    logic [31:0] HRDATA = '0;
    logic        HREADY = 1'b1, HRESP = 1'b0;

    logic [31:0] rdata0, rdata1, HADDR, HWDATA;
    logic        done0, err0, done1, err1, HWRITE;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;

    logic [31:0] f_rdata0, f_rdata1, f_HADDR, f_HWDATA;
    logic        f_done0, f_err0, f_done1, f_err1, f_HWRITE;
    logic [1:0]  f_HTRANS;
    logic [2:0]  f_HSIZE;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ahb_mem_arbiter #(.PRIORITY_MODE(0), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .rdata0(rdata0), .done0(done0), .err0(err0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .rdata1(rdata1), .done1(done1), .err1(err1),
        .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS), .HSIZE(HSIZE),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    ahb_mem_arbiter #(.PRIORITY_MODE(1), .TIMEOUT(4)) dut_fp (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .rdata0(f_rdata0), .done0(f_done0), .err0(f_err0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .rdata1(f_rdata1), .done1(f_done1), .err1(f_err1),
        .HADDR(f_HADDR), .HWRITE(f_HWRITE), .HTRANS(f_HTRANS), .HSIZE(f_HSIZE),
        .HWDATA(f_HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are changed and outputs checked mid-cycle.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [31:0] exp_addr;
        logic        exp_own;

        #1 reset = 1'b0;
        #1;
        chk("rst_htrans", 32'(HTRANS), 32'h0);
        chk("rst_haddr", HADDR, 32'h0);
        chk("rst_hsize", 32'(HSIZE), 32'h2);
        chk("rst_done", {30'd0, done1, done0}, 32'h0);
        chk("rst_err", {30'd0, err1, err0}, 32'h0);
        chk("rst_fp_hsize", 32'(f_HSIZE), 32'h2);
        tick();
        reset = 1'b1;

        // Single read, zero wait states
        req0 = 1'b1; addr0 = 32'h40; we0 = 1'b0;
        tick();
        HRDATA = 32'hDEADBEEF;
        #1;
        chk("rd_addr_htrans", 32'(HTRANS), 32'h2);
        chk("rd_addr_haddr", HADDR, 32'h40);
        chk("rd_addr_done", 32'(done0), 32'h0);
        tick();
        #1;
        chk("rd_data_htrans", 32'(HTRANS), 32'h0);
        chk("rd_data_haddr", HADDR, 32'h40);
        chk("rd_done0", 32'(done0), 32'h1);
        chk("rd_rdata0", rdata0, 32'hDEADBEEF);
        chk("rd_done1", 32'(done1), 32'h0);
        chk("rd_rdata1", rdata1, 32'h0);
        req0 = 1'b0;
        tick();
        #1;
        chk("rd_idle_done0", 32'(done0), 32'h0);
        chk("rd_idle_rdata0", rdata0, 32'h0);

        // Write with three data-phase wait states
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h100; wdata1 = 32'h12345678;
        tick();
        #1;
        chk("wr_addr_haddr", HADDR, 32'h100);
        chk("wr_addr_hwrite", 32'(HWRITE), 32'h1);
        chk("wr_addr_htrans", 32'(HTRANS), 32'h2);
        tick();
        HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("wr_wait%0d_hwdata", i), HWDATA, 32'h12345678);
            chk($sformatf("wr_wait%0d_done1", i), 32'(done1), 32'h0);
            chk($sformatf("wr_wait%0d_err1", i), 32'(err1), 32'h0);
            tick();
        end
        HREADY = 1'b1;
        #1;
        chk("wr_hwdata", HWDATA, 32'h12345678);
        chk("wr_hwrite_held", 32'(HWRITE), 32'h1);
        chk("wr_done1", 32'(done1), 32'h1);
        chk("wr_rdata1", rdata1, 32'h0);
        chk("wr_done0", 32'(done0), 32'h0);
        req1 = 1'b0; we1 = 1'b0;
        tick();

        // Contention: round-robin alternates 0,1,0,1; fixed priority always grants 0
        req0 = 1'b1; addr0 = 32'h200; req1 = 1'b1; addr1 = 32'h300;
        HRDATA = 32'h0000_A5A5;
        for (int t = 0; t < 4; t++) begin
            exp_own  = t[0];
            exp_addr = exp_own ? 32'h300 : 32'h200;
            tick();
            #1;
            chk($sformatf("rr_t%0d_haddr", t), HADDR, exp_addr);
            chk($sformatf("fp_t%0d_haddr", t), f_HADDR, 32'h200);
            tick();
            #1;
            chk($sformatf("rr_t%0d_done", t), {30'd0, done1, done0},
                exp_own ? 32'h2 : 32'h1);
            chk($sformatf("fp_t%0d_done", t), {30'd0, f_done1, f_done0}, 32'h1);
            tick();
        end
        req0 = 1'b0;
        tick();
        #1;
        chk("fp_drop_haddr", f_HADDR, 32'h300);
        chk("rr_drop_haddr", HADDR, 32'h300);
        tick();
        #1;
        chk("fp_drop_done1", 32'(f_done1), 32'h1);
        chk("rr_drop_done1", 32'(done1), 32'h1);
        req1 = 1'b0;
        tick();

        // Error response, then a normal transfer
        req0 = 1'b1; addr0 = 32'h44;
        tick();
        HRESP = 1'b1;
        tick();
        #1;
        chk("er_err0", 32'(err0), 32'h1);
        chk("er_done0", 32'(done0), 32'h0);
        chk("er_rdata0", rdata0, 32'h0);
        HRESP = 1'b0; addr0 = 32'h48; HRDATA = 32'hCAFEF00D;
        tick();
        #1;
        chk("er_idle_err0", 32'(err0), 32'h0);
        tick();
        #1;
        chk("er_next_haddr", HADDR, 32'h48);
        tick();
        #1;
        chk("er_next_done0", 32'(done0), 32'h1);
        chk("er_next_err0", 32'(err0), 32'h0);
        chk("er_next_rdata0", rdata0, 32'hCAFEF00D);
        req0 = 1'b0;
        tick();

        // Watchdog: HREADY stuck low in the address phase
        req1 = 1'b1; addr1 = 32'h500; HREADY = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            #1;
            chk($sformatf("to_c%0d_htrans", c), 32'(HTRANS), 32'h2);
            chk($sformatf("to_c%0d_err1", c), 32'(err1), 32'h0);
        end
        tick();
        #1;
        chk("to_c5_err1", 32'(err1), 32'h1);
        chk("to_c5_done1", 32'(done1), 32'h0);
        chk("to_c5_fp_err1", 32'(f_err1), 32'h1);
        req1 = 1'b0;
        tick();
        #1;
        chk("to_after_htrans", 32'(HTRANS), 32'h0);
        chk("to_after_err1", 32'(err1), 32'h0);
        HREADY = 1'b1;

        // Reset asserted in the data phase, then a tie after release
        req0 = 1'b1; addr0 = 32'h600; wdata0 = 32'h77;
        tick();
        tick();
        HREADY = 1'b0;
        #1;
        chk("rs_data_haddr", HADDR, 32'h600);
        reset = 1'b0;
        #1;
        chk("rs_htrans", 32'(HTRANS), 32'h0);
        chk("rs_haddr", HADDR, 32'h0);
        chk("rs_hwdata", HWDATA, 32'h0);
        chk("rs_done", {30'd0, done1, done0}, 32'h0);
        chk("rs_err", {30'd0, err1, err0}, 32'h0);
        req1 = 1'b1; addr1 = 32'h700; HREADY = 1'b1;
        tick();
        #1;
        chk("rs_hold_htrans", 32'(HTRANS), 32'h0);
        reset = 1'b1;
        tick();
        #1;
        chk("rs_first_haddr", HADDR, 32'h600);
        chk("rs_first_fp_haddr", f_HADDR, 32'h600);
        tick();
        #1;
        chk("rs_first_done0", 32'(done0), 32'h1);
        req0 = 1'b0; req1 = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
